instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the main control decoder: takes an instruction class plus operand fields, builds the 32-bit MIPS word, and streams it into instruction memory at sequential word addresses.
- Used by the bring-up/self-test path to program instruction memory before the pipeline is released.
- Covers exactly the opcode set the core decodes: R-type, LW, SW, BEQ, J, ADDI, ANDI, ORI, XORI, SLTI, LUI.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, number of words loadable per session; must satisfy DEPTH <= 2^ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- Start  in  1  pulse; opens a load session at word address 0.
- Finish  in  1  pulse; closes the session.
- In_valid  in  1  request valid.
- In_ready  out  1  encoder can accept a request.
- Op_sel  in  4  class: 0 R, 1 LW, 2 SW, 3 BEQ, 4 J, 5 ADDI, 6 ANDI, 7 ORI, 8 XORI, 9 SLTI, 10 LUI; 11-15 illegal.
- Rs, Rt, Rd, Shamt  in  5 each  register and shift fields.
- Funct  in  6  R-type function field.
- Imm  in  16  immediate.
- Target  in  26  jump target.
- Imem_we  out  1  instruction-memory write strobe.
- Imem_addr  out  ADDR_W  write word address.
- Imem_wdata  out  32  encoded instruction.
- Word_count  out  ADDR_W+1  words accepted in the current session.
- Done  out  1  one-cycle pulse when a session ends.
- Err  out  1  sticky illegal-Op_sel flag; cleared by Start or rst.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0. Imem_wdata is 0 and Word_count is 0.
- FSM states: IDLE, LOAD, FULL.
  - IDLE -> LOAD on Start.
  - LOAD -> FULL when the accepted word brings Word_count to DEPTH.
  - LOAD -> IDLE on Finish.
  - FULL -> IDLE on Finish.
  - Start in any state -> LOAD. This clears the address counter, Word_count and Err.
- In_ready = (state==LOAD) and not Start and not Finish.
- Accept occurs when In_valid and In_ready.
- Encoding, registered with 1-cycle latency. On accept at cycle N, at cycle N+1: Imem_we=1, Imem_addr = pre-accept counter, Imem_wdata = encoded word.
  - R: {000000,Rs,Rt,Rd,Shamt,Funct}.
  - LW 100011, SW 101011, BEQ 000100, ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010: {op,Rs,Rt,Imm}.
  - LUI: {001111,00000,Rt,Imm}. Rs is ignored and forced to 0.
  - J: {000010,Target}.
- Illegal Op_sel is still accepted, which consumes the handshake, but:
  - no write and no counter increment;
  - Err sets at N+1.
- Address counter and Word_count increment by 1 per legal accept.
  - The address counter is ADDR_W wide and wraps only if DEPTH = 2^ADDR_W. The session ends first.
- Back-to-back accepts every cycle are allowed; full throughput is 1 word/cycle.
- Imem_we is low in every cycle without a legal accept on the prior edge. Imem_addr and Imem_wdata hold their last values.
- Done pulses for one cycle:
  - in the cycle after entry to FULL, in parallel with the last write;
  - in the cycle after Finish from LOAD.
  - Finish in FULL returns to IDLE without a second Done.
- Simultaneous events:
  - Start with In_valid: no accept that cycle.
  - Finish with In_valid: no accept; session closes.
  - Start and Finish together: Start wins.
- A write registered on the edge before Start or Finish still completes the next cycle.
- rst mid-session: immediate IDLE; an in-flight Imem_we is dropped asynchronously.

Test Plan:
- Start, then ADDI Rs=0 Rt=8 Imm=5 -> next cycle Imem_we=1, addr 0, wdata 0x20080005; Word_count 1.
- Back-to-back requests:
  - R Rs=1 Rt=2 Rd=3 Shamt=0 Funct=0x20 -> 0x00221820 at addr 0;
  - LW Rs=1 Rt=2 Imm=4 -> 0x8C220004 at addr 1;
  - J Target=0x10 -> 0x08000010 at addr 2.
  - Imem_we is high 3 consecutive cycles.
- LUI Rs=7 Rt=1 Imm=0x1234 -> 0x3C011234 (Rs forced 0).
- Illegal Op_sel=12 between two legal ops -> no write for it, Err=1 and sticky, addresses stay contiguous (0,1). Start clears Err.
- DEPTH=4: 4 accepts -> last write at addr 3, Done pulses once, In_ready=0, fifth In_valid is ignored. Finish -> IDLE, no extra Done.
- Assert rst during a valid burst, one cycle after an accept -> Imem_we drops immediately, all outputs 0. Start afterwards begins again at addr 0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Builds 32-bit MIPS instruction words from a class select plus operand fields
// and streams them into instruction memory at sequential word addresses.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic              Finish,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [3:0]        Op_sel,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Shamt,
  input  logic [5:0]        Funct,
  input  logic [15:0]       Imm,
  input  logic [25:0]       Target,
  output logic              Imem_we,
  output logic [ADDR_W-1:0] Imem_addr,
  output logic [31:0]       Imem_wdata,
  output logic [ADDR_W:0]   Word_count,
  output logic              Done,
  output logic              Err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    SEL_R    = 4'd0,
    SEL_LW   = 4'd1,
    SEL_SW   = 4'd2,
    SEL_BEQ  = 4'd3,
    SEL_J    = 4'd4,
    SEL_ADDI = 4'd5,
    SEL_ANDI = 4'd6,
    SEL_ORI  = 4'd7,
    SEL_XORI = 4'd8,
    SEL_SLTI = 4'd9,
    SEL_LUI  = 4'd10
  } op_sel_t;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_ANDI = 6'b001100;
  localparam logic [5:0] OPC_ORI  = 6'b001101;
  localparam logic [5:0] OPC_XORI = 6'b001110;
  localparam logic [5:0] OPC_SLTI = 6'b001010;
  localparam logic [5:0] OPC_LUI  = 6'b001111;

  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

  state_t              state;
  logic [ADDR_W-1:0]   addr_cnt;
  logic                accept;
  logic                enc_legal;
  logic [31:0]         enc_word;

  // Start and Finish take priority over data, so the handshake is refused in
  // any cycle that carries either control pulse.
  assign In_ready = (state == LOAD) && !Start && !Finish;
  assign accept   = In_valid && In_ready;

  // NOTE: every output of an always_comb is given a default before the case so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    case (op_sel_t'(Op_sel))
      SEL_R:    enc_word = {OPC_R, Rs, Rt, Rd, Shamt, Funct};
      SEL_LW:   enc_word = {OPC_LW, Rs, Rt, Imm};
      SEL_SW:   enc_word = {OPC_SW, Rs, Rt, Imm};
      SEL_BEQ:  enc_word = {OPC_BEQ, Rs, Rt, Imm};
      SEL_J:    enc_word = {OPC_J, Target};
      SEL_ADDI: enc_word = {OPC_ADDI, Rs, Rt, Imm};
      SEL_ANDI: enc_word = {OPC_ANDI, Rs, Rt, Imm};
      SEL_ORI:  enc_word = {OPC_ORI, Rs, Rt, Imm};
      SEL_XORI: enc_word = {OPC_XORI, Rs, Rt, Imm};
      SEL_SLTI: enc_word = {OPC_SLTI, Rs, Rt, Imm};
      SEL_LUI:  enc_word = {OPC_LUI, 5'd0, Rt, Imm};
      default:  enc_legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_cnt   <= '0;
      Imem_we    <= 1'b0;
      Imem_addr  <= '0;
      Imem_wdata <= '0;
      Word_count <= '0;
      Done       <= 1'b0;
      Err        <= 1'b0;
    end else begin
      Imem_we <= 1'b0;
      Done    <= 1'b0;
      if (Start) begin
        state      <= LOAD;
        addr_cnt   <= '0;
        Word_count <= '0;
        Err        <= 1'b0;
      end else if (Finish) begin
        // Done already fired on entry to FULL; only a LOAD close reports it.
        if (state == LOAD) Done <= 1'b1;
        state <= IDLE;
      end else if (accept) begin
        if (enc_legal) begin
          Imem_we    <= 1'b1;
          Imem_addr  <= addr_cnt;
          Imem_wdata <= enc_word;
          addr_cnt   <= addr_cnt + ADDR_W'(1);
          Word_count <= Word_count + (ADDR_W + 1)'(1);
          if (Word_count == LAST_COUNT) begin
            state <= FULL;
            Done  <= 1'b1;
          end
        end else begin
          Err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed encoding table,
// multi-cycle corner sequences, and a randomized run against a session model.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              Start, Finish, In_valid, In_ready;
  logic [3:0]        Op_sel;
  logic [4:0]        Rs, Rt, Rd, Shamt;
  logic [5:0]        Funct;
  logic [15:0]       Imm;
  logic [25:0]       Target;
  logic              Imem_we;
  logic [ADDR_W-1:0] Imem_addr;
  logic [31:0]       Imem_wdata;
  logic [ADDR_W:0]   Word_count;
  logic              Done, Err;

  int n_checks = 0;
  int n_fail   = 0;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Finish(Finish),
    .In_valid(In_valid), .In_ready(In_ready), .Op_sel(Op_sel),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct),
    .Imm(Imm), .Target(Target), .Imem_we(Imem_we), .Imem_addr(Imem_addr),
    .Imem_wdata(Imem_wdata), .Word_count(Word_count), .Done(Done), .Err(Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  // Opcode per class, indexed by Op_sel.
  int unsigned opc_tab[11] = '{0, 35, 43, 4, 2, 8, 12, 13, 14, 10, 15};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int op, input int rs, input int rt, input int rd,
                              input int sh, input int fn, input int imm, input int tgt,
                              input logic [31:0] exp);
    vec_t v;
    v.op = 4'(op);  v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd); v.sh = 5'(sh);
    v.fn = 6'(fn);  v.imm = 16'(imm); v.tgt = 26'(tgt); v.exp = exp;
    return v;
  endfunction

  // Reference encoding from field positions using plain arithmetic.
  function automatic logic [32:0] ref_encode(input vec_t v);
    int unsigned w;
    int unsigned opc;
    if (v.op > 4'd10) return 33'd0;
    opc = opc_tab[v.op];
    if (v.op == 4'd0)
      w = v.rs * (32'd1 << 21) + v.rt * (32'd1 << 16) + v.rd * (32'd1 << 11) + v.sh * 64 + v.fn;
    else if (v.op == 4'd4)
      w = opc * (32'd1 << 26) + v.tgt;
    else if (v.op == 4'd10)
      w = opc * (32'd1 << 26) + v.rt * (32'd1 << 16) + v.imm;
    else
      w = opc * (32'd1 << 26) + v.rs * (32'd1 << 21) + v.rt * (32'd1 << 16) + v.imm;
    return {1'b1, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    In_valid = 1'b0; Op_sel = '0; Rs = '0; Rt = '0; Rd = '0; Shamt = '0;
    Funct = '0; Imm = '0; Target = '0;
  endtask

  task automatic set_req(input vec_t v);
    In_valid = 1'b1; Op_sel = v.op; Rs = v.rs; Rt = v.rt; Rd = v.rd;
    Shamt = v.sh; Funct = v.fn; Imm = v.imm; Target = v.tgt;
  endtask

  task automatic do_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic check_write(input string name, input int addr, input logic [31:0] data);
    check({name, "_we"}, 32'(Imem_we), 32'd1);
    check({name, "_addr"}, 32'(Imem_addr), 32'(addr));
    check({name, "_wdata"}, Imem_wdata, data);
  endtask

  // Session model state for the randomized run.
  bit          m_open;
  int          m_cnt;
  bit          m_err, m_we, m_done;
  int          m_addr;
  logic [31:0] m_wdata;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [32:0] enc;

    tbl[0]  = mk(5, 0, 8, 0, 0, 0, 16'h0005, 0, 32'h20080005);
    tbl[1]  = mk(0, 1, 2, 3, 0, 6'h20, 0, 0, 32'h00221820);
    tbl[2]  = mk(1, 1, 2, 0, 0, 0, 16'h0004, 0, 32'h8C220004);
    tbl[3]  = mk(4, 0, 0, 0, 0, 0, 0, 26'h10, 32'h08000010);
    tbl[4]  = mk(10, 7, 1, 0, 0, 0, 16'h1234, 0, 32'h3C011234);
    tbl[5]  = mk(2, 29, 31, 0, 0, 0, 16'hFFFC, 0, 32'hAFBFFFFC);
    tbl[6]  = mk(3, 4, 5, 0, 0, 0, 16'hFFFF, 0, 32'h1085FFFF);
    tbl[7]  = mk(6, 2, 3, 0, 0, 0, 16'h00FF, 0, 32'h304300FF);
    tbl[8]  = mk(7, 0, 9, 0, 0, 0, 16'hABCD, 0, 32'h3409ABCD);
    tbl[9]  = mk(8, 10, 11, 0, 0, 0, 16'h0001, 0, 32'h394B0001);
    tbl[10] = mk(9, 16, 17, 0, 0, 0, 16'h8000, 0, 32'h2A118000);
    tbl[11] = mk(0, 31, 0, 31, 31, 6'h3F, 0, 0, 32'h03E0FFFF);
    tbl[12] = mk(4, 0, 0, 0, 0, 0, 0, 26'h3FFFFFF, 32'h0BFFFFFF);

    rst = 1'b1; Start = 1'b0; Finish = 1'b0;
    clear_req();
    #12;
    check("rst_we", 32'(Imem_we), 32'd0);
    check("rst_addr", 32'(Imem_addr), 32'd0);
    check("rst_wdata", Imem_wdata, 32'd0);
    check("rst_count", 32'(Word_count), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_err", 32'(Err), 32'd0);
    check("rst_ready", 32'(In_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Idle: requests are refused before any Start.
    set_req(tbl[0]);
    @(negedge clk);
    check("idle_ready", 32'(In_ready), 32'd0);
    tick();
    clear_req();
    @(negedge clk);
    check("idle_no_we", 32'(Imem_we), 32'd0);
    tick();

    // Table: one request per session, each landing at address 0.
    for (int i = 0; i < 13; i++) begin
      do_start();
      set_req(tbl[i]);
      @(negedge clk);
      check($sformatf("tbl%0d_ready", i), 32'(In_ready), 32'd1);
      tick();
      clear_req();
      @(negedge clk);
      check_write($sformatf("tbl%0d", i), 0, tbl[i].exp);
      check($sformatf("tbl%0d_count", i), 32'(Word_count), 32'd1);
      tick();
    end

    // Back-to-back R, LW, J: three consecutive write cycles.
    do_start();
    set_req(tbl[1]); tick();
    set_req(tbl[2]); @(negedge clk); check_write("b2b0", 0, 32'h00221820); tick();
    set_req(tbl[3]); @(negedge clk); check_write("b2b1", 1, 32'h8C220004); tick();
    clear_req();     @(negedge clk); check_write("b2b2", 2, 32'h08000010);
    check("b2b_count", 32'(Word_count), 32'd3);
    tick();
    @(negedge clk); check("b2b_we_low", 32'(Imem_we), 32'd0);
    check("b2b_hold_wdata", Imem_wdata, 32'h08000010);
    tick();

    // Illegal Op_sel between two legal ops.
    do_start();
    set_req(tbl[0]); tick();
    v = tbl[0]; v.op = 4'd12;
    set_req(v);
    @(negedge clk); check_write("ill_a", 0, 32'h20080005);
    check("ill_ready", 32'(In_ready), 32'd1);
    tick();
    set_req(tbl[8]);
    @(negedge clk);
    check("ill_no_we", 32'(Imem_we), 32'd0);
    check("ill_err", 32'(Err), 32'd1);
    tick();
    clear_req();
    @(negedge clk);
    check_write("ill_b", 1, 32'h3409ABCD);
    check("ill_count", 32'(Word_count), 32'd2);
    tick(); tick();
    @(negedge clk); check("ill_err_sticky", 32'(Err), 32'd1);
    do_start();
    @(negedge clk);
    check("ill_err_cleared", 32'(Err), 32'd0);
    check("start_count_cleared", 32'(Word_count), 32'd0);
    tick();

    // Fill to DEPTH; fifth request ignored; Finish in FULL has no Done.
    do_start();
    v = tbl[0]; v.rt = 5'd0; v.imm = 16'd0;
    set_req(v); tick();
    for (int k = 1; k <= 4; k++) begin
      v = tbl[0]; v.rt = 5'(k); v.imm = 16'(k);
      set_req(v);
      @(negedge clk);
      check_write($sformatf("full%0d", k - 1), k - 1, 32'h20000000 + ((k - 1) << 16) + (k - 1));
      check($sformatf("full%0d_done", k - 1), 32'(Done), (k == 4) ? 32'd1 : 32'd0);
      check($sformatf("full%0d_ready", k - 1), 32'(In_ready), (k == 4) ? 32'd0 : 32'd1);
      tick();
    end
    @(negedge clk);
    check("full_extra_we", 32'(Imem_we), 32'd0);
    check("full_extra_done", 32'(Done), 32'd0);
    check("full_count", 32'(Word_count), 32'd4);
    clear_req();
    Finish = 1'b1; tick(); Finish = 1'b0;
    @(negedge clk);
    check("full_finish_done", 32'(Done), 32'd0);
    check("full_finish_ready", 32'(In_ready), 32'd0);
    tick();

    // Write registered just before Finish completes; Finish with In_valid is refused.
    do_start();
    set_req(tbl[9]); tick();
    Finish = 1'b1;
    @(negedge clk);
    check_write("fin_last", 0, 32'h394B0001);
    check("fin_ready", 32'(In_ready), 32'd0);
    tick();
    Finish = 1'b0; clear_req();
    @(negedge clk);
    check("fin_done", 32'(Done), 32'd1);
    check("fin_no_we", 32'(Imem_we), 32'd0);
    check("fin_count", 32'(Word_count), 32'd1);
    tick();
    @(negedge clk); check("fin_done_once", 32'(Done), 32'd0);

    // Start and Finish together: Start wins.
    #1; Start = 1'b1; Finish = 1'b1; tick(); Start = 1'b0; Finish = 1'b0;
    @(negedge clk);
    check("sf_ready", 32'(In_ready), 32'd1);
    check("sf_done", 32'(Done), 32'd0);
    tick();

    // Async reset while a write is on the outputs.
    do_start();
    set_req(tbl[2]); tick();
    set_req(tbl[3]);
    @(negedge clk);
    check("rstmid_we_before", 32'(Imem_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rstmid_we", 32'(Imem_we), 32'd0);
    check("rstmid_wdata", Imem_wdata, 32'd0);
    check("rstmid_count", 32'(Word_count), 32'd0);
    check("rstmid_ready", 32'(In_ready), 32'd0);
    check("rstmid_done_err", {30'd0, Done, Err}, 32'd0);
    tick();
    rst = 1'b0; clear_req();
    tick();
    do_start();
    set_req(tbl[2]); tick(); clear_req();
    @(negedge clk);
    check_write("rstmid_restart", 0, 32'h8C220004);
    check("rstmid_restart_count", 32'(Word_count), 32'd1);
    tick();

    // Randomized run against the session model.
    rst = 1'b1; #2; rst = 1'b0;
    m_open = 0; m_cnt = 0; m_err = 0; m_we = 0; m_done = 0; m_addr = 0; m_wdata = '0;
    tick();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bit exp_ready;
      Start    = ($urandom_range(0, 19) == 0);
      Finish   = ($urandom_range(0, 24) == 0);
      In_valid = ($urandom_range(0, 3) != 0);
      Op_sel = 4'($urandom_range(0, 15));
      Rs = 5'($urandom); Rt = 5'($urandom); Rd = 5'($urandom); Shamt = 5'($urandom);
      Funct = 6'($urandom); Imm = 16'($urandom); Target = 26'($urandom);
      exp_ready = m_open && (m_cnt < DEPTH) && !Start && !Finish;
      @(negedge clk);
      check("rnd_ready", 32'(In_ready), 32'(exp_ready));
      check("rnd_we", 32'(Imem_we), 32'(m_we));
      check("rnd_addr", 32'(Imem_addr), 32'(m_addr));
      check("rnd_wdata", Imem_wdata, m_wdata);
      check("rnd_count", 32'(Word_count), 32'(m_cnt));
      check("rnd_done", 32'(Done), 32'(m_done));
      check("rnd_err", 32'(Err), 32'(m_err));
      @(posedge clk);
      m_we = 0; m_done = 0;
      if (Start) begin
        m_open = 1; m_cnt = 0; m_err = 0;
      end else if (Finish) begin
        if (m_open && m_cnt < DEPTH) m_done = 1;
        m_open = 0;
      end else if (exp_ready && In_valid) begin
        v.op = Op_sel; v.rs = Rs; v.rt = Rt; v.rd = Rd; v.sh = Shamt;
        v.fn = Funct; v.imm = Imm; v.tgt = Target; v.exp = '0;
        enc = ref_encode(v);
        if (enc[32]) begin
          m_we = 1; m_addr = m_cnt % (1 << ADDR_W); m_wdata = enc[31:0];
          m_cnt++;
          if (m_cnt == DEPTH) m_done = 1;
        end else begin
          m_err = 1;
        end
      end
      #1;
    end
    Start = 1'b0; Finish = 1'b0; clear_req();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
